// File: rtl/game_pkg.sv
// Shared types and constants for the side-scroller frame controller.
package game_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    ERASE   = 4'd1,
    ERASE_W = 4'd2,
    MOVE    = 4'd3,
    MOVE_W  = 4'd4,
    DRAW    = 4'd5,
    DRAW_W  = 4'd6,
    CHECK   = 4'd7,
    CHECK_W = 4'd8,
    HALT    = 4'd9
  } state_e;

  localparam int unsigned OBJ_W       = 2;
  localparam int unsigned FRAME_CNT_W = 16;

  localparam logic [OBJ_W-1:0] OBJ_PLAYER = 2'd0;
  localparam logic [OBJ_W-1:0] OBJ_B0     = 2'd1;
  localparam logic [OBJ_W-1:0] OBJ_B1     = 2'd2;

endpackage

// File: rtl/step_divider.sv
// Mod-STEP_DIV frame counter; last flags the frame on which boulders advance.
module step_divider #(
  parameter int unsigned STEP_DIV = 4
) (
  input  logic clock,
  input  logic resetn,
  input  logic advance,
  output logic last
);

  localparam int unsigned CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (advance) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CNT_MAX);

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame erase/move/draw/collide sequencer; freezes on game over.
// Optional handshake watchdog: define FRAME_SEQ_WATCHDOG_EN.
module frame_sequencer
  import game_pkg::*;
#(
  parameter int unsigned NUM_OBJ   = 3,
  parameter int unsigned STEP_DIV  = 4,
  parameter int unsigned WD_CYCLES = 1023
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   frame_tick,
  input  logic                   plot_done,
  input  logic                   move_done,
  input  logic                   cd_done,
  input  logic                   gg,
  output logic                   plot_go,
  output logic                   plot_erase,
  output logic [OBJ_W-1:0]       obj_sel,
  output logic                   move_go,
  output logic                   move_boulders,
  output logic                   cd_go,
  output logic                   busy,
  output logic                   overrun,
  output logic                   halted,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam logic [OBJ_W-1:0] OBJ_LAST = OBJ_W'(NUM_OBJ - 1);

  if (WD_CYCLES < 2) begin : g_wd_check
    $error("WD_CYCLES must be at least 2");
  end

  state_e                 state_q, state_d;
  logic [OBJ_W-1:0]       obj_q, obj_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   overrun_q, overrun_d;
  logic                   plot_go_q, plot_go_d;
  logic                   plot_erase_q, plot_erase_d;
  logic [OBJ_W-1:0]       obj_sel_q, obj_sel_d;
  logic                   move_go_q, move_go_d;
  logic                   move_boulders_q, move_boulders_d;
  logic                   cd_go_q, cd_go_d;
  logic                   busy_q, busy_d;
  logic                   halted_q, halted_d;
  logic                   step_adv, step_last;
  logic                   wd_abort;

  step_divider #(.STEP_DIV(STEP_DIV)) u_step_divider (
    .clock   (clock),
    .resetn  (resetn),
    .advance (step_adv),
    .last    (step_last)
  );

`ifdef FRAME_SEQ_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WD_CYCLES);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            in_wait, done_now;

  // Counts cycles spent in a wait state; restarts whenever a wait is left.
  always_comb begin
    wd_d     = '0;
    wd_abort = 1'b0;
    in_wait  = (state_q == ERASE_W) || (state_q == MOVE_W) ||
               (state_q == DRAW_W)  || (state_q == CHECK_W);
    done_now = ((state_q == ERASE_W) && plot_done) || ((state_q == DRAW_W) && plot_done) ||
               ((state_q == MOVE_W) && move_done)  || ((state_q == CHECK_W) && cd_done);
    if (in_wait && !done_now) begin
      if (wd_q == WD_W'(WD_CYCLES - 1)) begin
        wd_abort = 1'b1;
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign wd_abort = 1'b0;
`endif

  // Next state plus registered output decode of the state being entered.
  always_comb begin
    state_d     = state_q;
    obj_d       = obj_q;
    frame_cnt_d = frame_cnt_q;
    overrun_d   = overrun_q;
    step_adv    = 1'b0;

    if (frame_tick && (state_q != IDLE) && (state_q != HALT)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (frame_tick) begin
          state_d = ERASE;
          obj_d   = OBJ_PLAYER;
        end
      end
      ERASE:   state_d = ERASE_W;
      ERASE_W: begin
        if (plot_done) begin
          if (obj_q == OBJ_LAST) begin
            state_d = MOVE;
            obj_d   = OBJ_PLAYER;
          end else begin
            state_d = ERASE;
            obj_d   = obj_q + OBJ_W'(1);
          end
        end
      end
      MOVE:    state_d = MOVE_W;
      MOVE_W:  if (move_done) state_d = DRAW;
      DRAW:    state_d = DRAW_W;
      DRAW_W: begin
        if (plot_done) begin
          if (obj_q == OBJ_LAST) begin
            state_d = CHECK;
            obj_d   = OBJ_PLAYER;
          end else begin
            state_d = DRAW;
            obj_d   = obj_q + OBJ_W'(1);
          end
        end
      end
      CHECK:   state_d = CHECK_W;
      CHECK_W: begin
        if (cd_done) begin
          frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
          step_adv    = 1'b1;
          state_d     = gg ? HALT : IDLE;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase

    if (wd_abort) begin
      state_d   = IDLE;
      obj_d     = OBJ_PLAYER;
      overrun_d = 1'b1;
    end

    plot_go_d       = (state_d == ERASE) || (state_d == DRAW);
    plot_erase_d    = (state_d == ERASE) || (state_d == ERASE_W);
    obj_sel_d       = ((state_d == ERASE) || (state_d == ERASE_W) ||
                       (state_d == DRAW)  || (state_d == DRAW_W)) ? obj_d : OBJ_PLAYER;
    move_go_d       = (state_d == MOVE);
    move_boulders_d = (state_d == MOVE) && step_last;
    cd_go_d         = (state_d == CHECK);
    busy_d          = (state_d != IDLE) && (state_d != HALT);
    halted_d        = (state_d == HALT);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q         <= IDLE;
      obj_q           <= OBJ_PLAYER;
      frame_cnt_q     <= '0;
      overrun_q       <= 1'b0;
      plot_go_q       <= 1'b0;
      plot_erase_q    <= 1'b0;
      obj_sel_q       <= '0;
      move_go_q       <= 1'b0;
      move_boulders_q <= 1'b0;
      cd_go_q         <= 1'b0;
      busy_q          <= 1'b0;
      halted_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      obj_q           <= obj_d;
      frame_cnt_q     <= frame_cnt_d;
      overrun_q       <= overrun_d;
      plot_go_q       <= plot_go_d;
      plot_erase_q    <= plot_erase_d;
      obj_sel_q       <= obj_sel_d;
      move_go_q       <= move_go_d;
      move_boulders_q <= move_boulders_d;
      cd_go_q         <= cd_go_d;
      busy_q          <= busy_d;
      halted_q        <= halted_d;
    end
  end

  assign plot_go       = plot_go_q;
  assign plot_erase    = plot_erase_q;
  assign obj_sel       = obj_sel_q;
  assign move_go       = move_go_q;
  assign move_boulders = move_boulders_q;
  assign cd_go         = cd_go_q;
  assign busy          = busy_q;
  assign overrun       = overrun_q;
  assign halted        = halted_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer: expected go events queued per tick, checked as they appear.
module tb_frame_sequencer;

  localparam int unsigned STEP_DIV  = 4;
  localparam int unsigned WD_CYCLES = 15;

  logic        clock, resetn, frame_tick, plot_done, move_done, cd_done, gg;
  logic        plot_go, plot_erase, move_go, move_boulders, cd_go, busy, overrun, halted;
  logic [1:0]  obj_sel;
  logic [15:0] frame_cnt;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [5:0]  exp_q[$];
  bit          hold_plot = 1'b0;
  bit          hold_move = 1'b0;
  int          inject_req = 0;
  int          inject_ack = 0;
  int unsigned step_m = 0;
  int          plot_go_cycles = 0;
  bit          pend_plot, pend_move, pend_cd;
  logic [1:0]  cur_obj;
  logic        cur_erase;

  frame_sequencer #(.NUM_OBJ(3), .STEP_DIV(STEP_DIV), .WD_CYCLES(WD_CYCLES)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .frame_tick    (frame_tick),
    .plot_done     (plot_done),
    .move_done     (move_done),
    .cd_done       (cd_done),
    .gg            (gg),
    .plot_go       (plot_go),
    .plot_erase    (plot_erase),
    .obj_sel       (obj_sel),
    .move_go       (move_go),
    .move_boulders (move_boulders),
    .cd_go         (cd_go),
    .busy          (busy),
    .overrun       (overrun),
    .halted        (halted),
    .frame_cnt     (frame_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [5:0] ev(input logic [1:0] kind, input logic [1:0] obj,
                                    input logic erase, input logic mb);
    return {kind, obj, erase, mb};
  endfunction

  // Queue the first 'upto' go events of a frame; a full frame advances the step model.
  task automatic push_frame(input int upto);
    logic [5:0] evs [8];
    for (int i = 0; i < 3; i++) begin
      evs[i]     = ev(2'd1, 2'(i), 1'b1, 1'b0);
      evs[4 + i] = ev(2'd1, 2'(i), 1'b0, 1'b0);
    end
    evs[3] = ev(2'd2, 2'd0, 1'b0, (step_m == STEP_DIV - 1));
    evs[7] = ev(2'd3, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < upto; i++) exp_q.push_back(evs[i]);
    if (upto == 8) step_m = (step_m + 1) % STEP_DIV;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({plot_go, plot_erase, obj_sel, move_go, move_boulders, cd_go,
                busy, overrun, halted, frame_cnt});
  endfunction

  task automatic tick();
    @(negedge clock) frame_tick = 1'b1;
    @(negedge clock) frame_tick = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock) resetn = 1'b0;
    @(negedge clock) resetn = 1'b1;
    step_m = 0;
    exp_q.delete();
    check(tag, all_outs(), 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clock);
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  // Responder and monitor: answers go pulses one wait-state cycle later, scores every go.
  initial begin
    logic [5:0] obs, e;
    plot_done = 1'b0; move_done = 1'b0; cd_done = 1'b0;
    pend_plot = 1'b0; pend_move = 1'b0; pend_cd = 1'b0;
    forever begin
      @(negedge clock);
      plot_done = pend_plot;
      move_done = pend_move;
      cd_done   = pend_cd;
      if (inject_req != inject_ack) begin
        move_done  = 1'b1;
        inject_ack = inject_req;
      end
      if (pend_plot) begin
        check("obj_sel_hold", 32'(obj_sel), 32'(cur_obj));
        check("plot_erase_hold", 32'(plot_erase), 32'(cur_erase));
      end
      pend_plot = 1'b0; pend_move = 1'b0; pend_cd = 1'b0;
      if (plot_go) plot_go_cycles++;
      if (plot_go || move_go || cd_go) begin
        obs = ev(plot_go ? 2'd1 : (move_go ? 2'd2 : 2'd3), obj_sel, plot_erase, move_boulders);
        if (exp_q.size() == 0) begin
          check("unexpected_go", 32'(obs), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("go_event", 32'(obs), 32'(e));
          cur_obj   = e[3:2];
          cur_erase = e[1];
        end
        pend_plot = plot_go && !hold_plot;
        pend_move = move_go && !hold_move;
        pend_cd   = cd_go;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit found;
    resetn = 1'b0; frame_tick = 1'b0; gg = 1'b0;
    repeat (3) @(negedge clock);
    do_reset("reset_outputs");

    // One frame with prompt dones.
    plot_go_cycles = 0;
    push_frame(8);
    tick();
    wait_idle("frame1_idle");
    check("frame1_cnt", 32'(frame_cnt), 32'd1);
    check("frame1_plot_go_cycles", 32'(plot_go_cycles), 32'd6);
    check("frame1_overrun", 32'(overrun), 32'd0);

    // Seven more frames: boulders advance on frames 4 and 8.
    for (int f = 2; f <= 8; f++) begin
      push_frame(8);
      tick();
      wait_idle("step_frame_idle");
    end
    check("step_frames_cnt", 32'(frame_cnt), 32'd8);

    // Extra tick while waiting on a draw.
    push_frame(8);
    tick();
    n = 0; found = 1'b0;
    while (!found && n < 100) begin
      @(negedge clock);
      n++;
      found = plot_go && !plot_erase;
    end
    check("draw_go_seen", 32'(found), 32'd1);
    @(negedge clock) frame_tick = 1'b1;
    @(negedge clock) frame_tick = 1'b0;
    wait_idle("overrun_frame_idle");
    check("overrun_set", 32'(overrun), 32'd1);
    check("overrun_frame_cnt", 32'(frame_cnt), 32'd9);
    repeat (20) @(negedge clock);
    check("no_extra_frame_busy", 32'(busy), 32'd0);
    check("no_extra_frame_cnt", 32'(frame_cnt), 32'd9);

    // Game over freezes the sequencer until reset.
    do_reset("reset_before_gg");
    gg = 1'b1;
    push_frame(8);
    tick();
    wait_idle("gg_frame_idle");
    check("gg_halted", 32'(halted), 32'd1);
    check("gg_frame_cnt", 32'(frame_cnt), 32'd1);
    tick();
    repeat (5) @(negedge clock);
    tick();
    repeat (10) @(negedge clock);
    check("halt_no_events", 32'(exp_q.size()), 32'd0);
    check("halt_frame_cnt", 32'(frame_cnt), 32'd1);
    check("halt_overrun", 32'(overrun), 32'd0);
    check("halt_busy", 32'(busy), 32'd0);
    check("halt_still", 32'(halted), 32'd1);
    gg = 1'b0;
    do_reset("reset_from_halt");

    // Reset while waiting on the movers; a late move_done is ignored.
    hold_move = 1'b1;
    push_frame(4);
    tick();
    n = 0;
    while (!move_go && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("move_go_seen", 32'(move_go), 32'd1);
    @(negedge clock) resetn = 1'b0;
    @(negedge clock) resetn = 1'b1;
    check("reset_mid_move", all_outs(), 32'd0);
    hold_move = 1'b0;
    inject_req++;
    repeat (10) @(negedge clock);
    check("late_move_done_busy", 32'(busy), 32'd0);
    check("late_move_done_cnt", 32'(frame_cnt), 32'd0);
    check("late_move_done_events", 32'(exp_q.size()), 32'd0);

`ifdef FRAME_SEQ_WATCHDOG_EN
    // Plotter never answers: watchdog aborts the frame.
    hold_plot = 1'b1;
    push_frame(1);
    tick();
    n = 1;
    while (busy && n < 200) begin
      @(negedge clock);
      if (busy) n++;
    end
    check("wd_busy_cycles", 32'(n), 32'(WD_CYCLES + 1));
    check("wd_overrun", 32'(overrun), 32'd1);
    check("wd_frame_cnt", 32'(frame_cnt), 32'd0);
    check("wd_idle", 32'(busy), 32'd0);
    hold_plot = 1'b0;
`endif

    repeat (3) @(negedge clock);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
